// File: rtl/llr_frame_buffer.sv
// Ping-pong LLR frame buffer: one bank fills while the other streams out through a
// two-stage RAM read pipeline into a 4-entry output FIFO.
module llr_frame_buffer #(
    parameter int CODE_LEN = 256,
    parameter int SYM_W    = 15,
    parameter int LANES    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [LANES*SYM_W-1:0] wr_data,
    input  logic                   wr_last,
    input  logic                   rd_start,
    output logic                   rd_ack,
    output logic                   rd_busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*SYM_W-1:0] out_data,
    output logic                   out_last,
    output logic [1:0]             bank_full,
    output logic                   err_len
);
    localparam int DW    = LANES * SYM_W;
    localparam int DEPTH = CODE_LEN / LANES;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    logic [DW-1:0] mem [0:(2 << AW) - 1];
    logic [DW-1:0] ram_rdata_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    rd_state_t     state_q, state_d;
    logic          rd_ack_q, rd_ack_d, rd_busy_q, rd_busy_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          err_len_q, err_len_d;
    logic          s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic          s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic [DW:0]   fifo_q [4];
    logic [DW:0]   fifo_d [4];
    logic [1:0]    fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [2:0]    fifo_cnt_q, fifo_cnt_d;
    logic          wr_fire_s, rd_issue_s, pop_s;

    assign wr_ready   = ~bank_full_q[wr_bank_q] & ~flush;
    assign wr_fire_s  = wr_valid & wr_ready;
    assign out_valid  = (fifo_cnt_q != 3'd0);
    assign pop_s      = out_valid & out_ready;
    // Only issue while every outstanding read is guaranteed a FIFO slot.
    assign rd_issue_s = (state_q == ISSUE) &&
                        ((fifo_cnt_q + {2'b00, s1_vld_q} + {2'b00, s2_vld_q}) < 3'd4);
    assign out_data   = out_valid ? fifo_q[fifo_rp_q][DW-1:0] : '0;
    assign out_last   = out_valid & fifo_q[fifo_rp_q][DW];
    assign rd_ack     = rd_ack_q;
    assign rd_busy    = rd_busy_q;
    assign bank_full  = bank_full_q;
    assign err_len    = err_len_q;

    // Symbol RAM with registered read port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem[{wr_bank_q, wr_ptr_q}] <= wr_data;
        end
        ram_rdata_q <= mem[{rd_bank_q, rd_ptr_q}];
    end

    // Next-state logic for write side, read FSM, read pipeline and output FIFO.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        state_d     = state_q;
        rd_ack_d    = 1'b0;
        rd_busy_d   = rd_busy_q;
        bank_full_d = bank_full_q;
        err_len_d   = err_len_q;
        s1_vld_d    = rd_issue_s;
        s1_last_d   = rd_issue_s & (rd_ptr_q == LAST_PTR);
        s2_vld_d    = s1_vld_q;
        s2_last_d   = s1_last_q;
        s2_data_d   = ram_rdata_q;
        fifo_wp_d   = fifo_wp_q;
        fifo_rp_d   = fifo_rp_q;
        fifo_cnt_d  = fifo_cnt_q + {2'b00, s2_vld_q} - {2'b00, pop_s};
        for (int i = 0; i < 4; i++) begin
            fifo_d[i] = fifo_q[i];
        end

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            state_d     = IDLE;
            rd_busy_d   = 1'b0;
            bank_full_d = 2'b00;
            err_len_d   = 1'b0;
            s1_vld_d    = 1'b0;
            s1_last_d   = 1'b0;
            s2_vld_d    = 1'b0;
            s2_last_d   = 1'b0;
            s2_data_d   = '0;
            fifo_wp_d   = 2'd0;
            fifo_rp_d   = 2'd0;
            fifo_cnt_d  = 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_d[i] = '0;
            end
        end else begin
            // A final beat always commits; a short frame is dropped.
            if (wr_fire_s) begin
                if (wr_ptr_q == LAST_PTR) begin
                    bank_full_d[wr_bank_q] = 1'b1;
                    wr_ptr_d  = '0;
                    wr_bank_d = ~wr_bank_q;
                    err_len_d = err_len_q | ~wr_last;
                end else if (wr_last) begin
                    wr_ptr_d  = '0;
                    err_len_d = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            case (state_q)
                IDLE: begin
                    if (rd_start && bank_full_q[rd_bank_q]) begin
                        rd_ack_d  = 1'b1;
                        rd_busy_d = 1'b1;
                        rd_ptr_d  = '0;
                        state_d   = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ISSUE: begin
                    if (rd_issue_s && (rd_ptr_q == LAST_PTR)) begin
                        rd_ptr_d = '0;
                        state_d  = DRAIN;
                    end else if (rd_issue_s) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end else begin
                        state_d = ISSUE;
                    end
                end
                DRAIN: begin
                    if (pop_s && out_last) begin
                        bank_full_d[rd_bank_q] = 1'b0;
                        rd_bank_d = ~rd_bank_q;
                        rd_busy_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    rd_busy_d = 1'b0;
                    state_d   = IDLE;
                end
            endcase

            if (s2_vld_q) begin
                fifo_d[fifo_wp_q] = {s2_last_q, s2_data_q};
                fifo_wp_d = fifo_wp_q + 2'd1;
            end else begin
                fifo_wp_d = fifo_wp_q;
            end
            if (pop_s) begin
                fifo_rp_d = fifo_rp_q + 2'd1;
            end else begin
                fifo_rp_d = fifo_rp_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            state_q     <= IDLE;
            rd_ack_q    <= 1'b0;
            rd_busy_q   <= 1'b0;
            bank_full_q <= 2'b00;
            err_len_q   <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_data_q   <= '0;
            fifo_wp_q   <= 2'd0;
            fifo_rp_q   <= 2'd0;
            fifo_cnt_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            state_q     <= state_d;
            rd_ack_q    <= rd_ack_d;
            rd_busy_q   <= rd_busy_d;
            bank_full_q <= bank_full_d;
            err_len_q   <= err_len_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s2_vld_q    <= s2_vld_d;
            s2_last_q   <= s2_last_d;
            s2_data_q   <= s2_data_d;
            fifo_wp_q   <= fifo_wp_d;
            fifo_rp_q   <= fifo_rp_d;
            fifo_cnt_q  <= fifo_cnt_d;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end
endmodule
